// File: rtl/regfile_dxw_1clk.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dxw_1clk
//  Purpose  : Parametrised register file (DEPTH x DW) with per-bit write
//             mask, one-clock registered read with valid/error flags,
//             optional write-to-read bypass and a hardware init sweep that
//             fills every entry with INIT_VAL after reset or on clr_i.
//  Ports    : clk      - clock, rising edge
//             rst_n    - synchronous active-low reset
//             clr_i    - request a re-initialisation sweep (READY only)
//             wen_i    - write enable; waddr_i / wdata_i / wmask_i
//             ren_i    - read enable; raddr_i
//             rdata_o  - registered read data
//             rvalid_o - one-cycle pulse, rdata_o/rerr_o updated
//             rerr_o   - read address out of range (qualified by rvalid_o)
//             busy_o   - init sweep in progress, requests ignored
//  Revision : 1.0  initial release
// ============================================================================
module regfile_dxw_1clk #(
    parameter int              DEPTH    = 4,
    parameter int              AW       = 2,
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   INIT_VAL = {DW{1'b0}},
    parameter bit              BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            wen_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW-1:0]   wmask_i,
    input  logic            ren_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DW-1:0]   rdata_o,
    output logic            rvalid_o,
    output logic            rerr_o,
    output logic            busy_o
);

    // One extra bit so DEPTH == 2^AW is representable for the range compare.
    localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_cnt;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [DW-1:0]   r_rdata;
    logic            r_rvalid;
    logic            r_rerr;

    logic            w_busy;
    logic            w_waddr_ok;
    logic            w_raddr_ok;
    logic            w_wr_ok;
    logic            w_collide;
    logic [DW-1:0]   w_merged;
    logic [DW-1:0]   w_rd_word;

    assign w_busy     = (r_state == ST_INIT);
    assign w_waddr_ok = ({1'b0, waddr_i} < c_depth);
    assign w_raddr_ok = ({1'b0, raddr_i} < c_depth);

    // A clr_i request in READY drops any access in the same cycle.
    assign w_wr_ok    = !w_busy && !clr_i && wen_i && w_waddr_ok;
    assign w_collide  = w_wr_ok && (waddr_i == raddr_i);

    always_comb begin
        w_merged  = {DW{1'b0}};
        w_rd_word = {DW{1'b0}};
        if (w_waddr_ok) begin
            w_merged = (r_mem[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
        end
        if (w_raddr_ok) begin
            w_rd_word = r_mem[raddr_i];
        end
        if (BYPASS && w_collide) begin
            w_rd_word = w_merged;
        end
    end

    // Storage array: never reset directly; the sweep provides known content.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_busy) begin
                r_mem[r_cnt] <= INIT_VAL;
            end else if (w_wr_ok) begin
                r_mem[waddr_i] <= w_merged;
            end
        end
    end

    // Control FSM and registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_INIT;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_rerr   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rvalid <= 1'b0;
                    r_rerr   <= 1'b0;
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_state <= ST_READY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr_i) begin
                        r_state  <= ST_INIT;
                        r_cnt    <= '0;
                        r_rvalid <= 1'b0;
                        r_rerr   <= 1'b0;
                    end else if (ren_i) begin
                        r_rvalid <= 1'b1;
                        if (w_raddr_ok) begin
                            r_rdata <= w_rd_word;
                            r_rerr  <= 1'b0;
                        end else begin
                            r_rdata <= '0;
                            r_rerr  <= 1'b1;
                        end
                    end else begin
                        // rdata_o holds its last value when no read is issued.
                        r_rvalid <= 1'b0;
                        r_rerr   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;
    assign rerr_o   = r_rerr;
    assign busy_o   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dxw_1clk.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_dxw_1clk
//  Purpose  : Self-checking bench. Two instances (BYPASS=1 and BYPASS=0,
//             DEPTH=5, AW=3) share stimulus; a behavioural model of the
//             storage contents and sweep length predicts every output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_dxw_1clk;

    localparam int         DEPTH = 5;
    localparam int         AW    = 3;
    localparam int         DW    = 8;
    localparam logic [7:0] IVAL  = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n, clr, wen, ren;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata, wmask;
    logic [DW-1:0] rdata1, rdata0;
    logic          rvalid1, rvalid0, rerr1, rerr0, busy1, busy0;

    always #5 clk = ~clk;

    regfile_dxw_1clk #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT_VAL(IVAL), .BYPASS(1'b1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .wen_i(wen), .waddr_i(waddr),
        .wdata_i(wdata), .wmask_i(wmask), .ren_i(ren), .raddr_i(raddr),
        .rdata_o(rdata1), .rvalid_o(rvalid1), .rerr_o(rerr1), .busy_o(busy1));

    regfile_dxw_1clk #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT_VAL(IVAL), .BYPASS(1'b0)) u_dut_nobyp (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .wen_i(wen), .waddr_i(waddr),
        .wdata_i(wdata), .wmask_i(wmask), .ren_i(ren), .raddr_i(raddr),
        .rdata_o(rdata0), .rvalid_o(rvalid0), .rerr_o(rerr0), .busy_o(busy0));

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: entry contents, remaining sweep edges, read outputs.
    logic [7:0] m_mem [DEPTH];
    int         m_left;
    logic [7:0] m_rd1, m_rd0;
    logic       m_rv, m_re;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    // Advance the model by one edge using the current inputs, clock the
    // DUTs, then compare every output away from the edge.
    task automatic step();
        logic [7:0] nv;
        if (!rst_n) begin
            m_left = DEPTH; m_rv = 1'b0; m_re = 1'b0; m_rd1 = '0; m_rd0 = '0;
        end else if (m_left > 0) begin
            m_mem[DEPTH - m_left] = IVAL;
            m_left--;
            m_rv = 1'b0; m_re = 1'b0;
        end else if (clr) begin
            m_left = DEPTH; m_rv = 1'b0; m_re = 1'b0;
        end else begin
            if (ren) begin
                m_rv = 1'b1;
                if (int'(raddr) < DEPTH) begin
                    m_re  = 1'b0;
                    m_rd0 = m_mem[raddr];
                    m_rd1 = m_mem[raddr];
                    if (wen && waddr == raddr)
                        m_rd1 = (m_mem[raddr] & ~wmask) | (wdata & wmask);
                end else begin
                    m_re = 1'b1; m_rd0 = '0; m_rd1 = '0;
                end
            end else begin
                m_rv = 1'b0; m_re = 1'b0;
            end
            if (wen && int'(waddr) < DEPTH) begin
                nv = (m_mem[waddr] & ~wmask) | (wdata & wmask);
                m_mem[waddr] = nv;
            end
        end
        @(posedge clk);
        #1;
        chk("busy_byp",    busy1,   m_left > 0);
        chk("busy_nobyp",  busy0,   m_left > 0);
        chk("rvalid_byp",  rvalid1, m_rv);
        chk("rvalid_nobyp",rvalid0, m_rv);
        chk("rerr_byp",    rerr1,   m_re);
        chk("rerr_nobyp",  rerr0,   m_re);
        chk("rdata_byp",   rdata1,  m_rd1);
        chk("rdata_nobyp", rdata0,  m_rd0);
    endtask

    task automatic cyc(input logic c, input logic we, input int wa, input logic [7:0] wd,
                       input logic [7:0] wm, input logic re, input int ra);
        clr = c; wen = we; waddr = AW'(wa); wdata = wd; wmask = wm; ren = re; raddr = AW'(ra);
        step();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b0, 0);
    endtask

    // Count idle edges until busy drops (bounded).
    task automatic wait_sweep(output int n);
        n = 0;
        while (busy1 && n < 20) begin
            idle();
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; clr = 1'b0; wen = 1'b0; ren = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; wmask = '0;
        m_left = DEPTH; m_rv = 1'b0; m_re = 1'b0; m_rd1 = '0; m_rd0 = '0;

        // Reset and sweep length.
        step(); step();
        chk("rst_rdata", rdata1, 8'h00);
        rst_n = 1'b1;
        wait_sweep(n);
        chk("sweep_len", n, DEPTH);

        // Post-sweep contents.
        for (int a = 0; a < DEPTH; a++) begin
            cyc(1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b1, a);
            chk("init_rd", rdata1, 8'hA5);
        end

        // Masked write merge.
        cyc(1'b0, 1'b1, 2, 8'h3C, 8'hFF, 1'b0, 0);
        cyc(1'b0, 1'b1, 2, 8'hFF, 8'h0F, 1'b0, 0);
        cyc(1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b1, 2);
        chk("mask_merge", rdata1, 8'h3F);

        // Same-cycle write/read collision.
        cyc(1'b0, 1'b1, 1, 8'h00, 8'hFF, 1'b0, 0);
        cyc(1'b0, 1'b1, 1, 8'h55, 8'hFF, 1'b1, 1);
        chk("bypass_new", rdata1, 8'h55);
        chk("nobypass_old", rdata0, 8'h00);
        cyc(1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b1, 1);
        chk("after_coll", rdata0, 8'h55);

        // Out-of-range read and dropped write.
        cyc(1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b1, 6);
        chk("oor_rerr", rerr1, 1'b1);
        cyc(1'b0, 1'b1, 7, 8'h12, 8'hFF, 1'b0, 0);
        for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b1, a);

        // clr_i with concurrent write to addr 0: write dropped, full sweep.
        cyc(1'b1, 1'b1, 0, 8'h77, 8'hFF, 1'b1, 0);
        wait_sweep(n);
        chk("clr_sweep_len", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            cyc(1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b1, a);
            chk("clr_rd", rdata1, 8'hA5);
        end

        // clr_i during the sweep must not extend it.
        cyc(1'b1, 1'b0, 0, 8'h00, 8'h00, 1'b0, 0);
        n = 0;
        while (busy1 && n < 20) begin
            cyc(n == 2, 1'b0, 0, 8'h00, 8'h00, 1'b0, 0);
            n++;
        end
        chk("clr_in_init_len", n, DEPTH);

        // Continuous reads with a one-cycle reset mid-stream.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b1, i);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b1, 3);
        chk("midrst_rvalid", rvalid1, 1'b0);
        chk("midrst_rdata", rdata1, 8'h00);
        chk("midrst_busy", busy1, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) cyc(1'b0, 1'b0, 0, 8'h00, 8'h00, 1'b1, i % DEPTH);

        // Randomised traffic with occasional clr_i and reset.
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            cyc($urandom_range(0, 39) == 0, 1'($urandom), int'($urandom_range(0, 7)),
                8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_dxw_1clk.md
# regfile_dxw_1clk

Parametrised register file with configurable depth and width, per-bit write mask, registered read with valid and error flags, optional write-to-read bypass, and a hardware initialisation sweep after reset or on request. It is the general-purpose storage block for the bridge and its peripherals: it replaces fixed 4-entry register files wherever depth, width, masking or a known post-reset content is required. Read data is returned one clock after the request.

## Interface
- DEPTH, 4, number of entries (2..256)
- AW, 2, address width; must satisfy 2^AW >= DEPTH
- DW, 8, data width (1..64)
- INIT_VAL, {DW{1'b0}}, value written into every entry by the init sweep
- BYPASS, 1, 1: a same-cycle write to the read address returns the new data; 0: returns the old data

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- clr_i  in  1  request a re-initialisation sweep
- wen_i  in  1  write enable
- waddr_i  in  AW  write address
- wdata_i  in  DW  write data
- wmask_i  in  DW  per-bit write mask; 1 = bit is written
- ren_i  in  1  read enable
- raddr_i  in  AW  read address
- rdata_o  out  DW  registered read data
- rvalid_o  out  1  one-cycle pulse: rdata_o/rerr_o updated
- rerr_o  out  1  read address out of range, qualified by rvalid_o
- busy_o  out  1  init sweep in progress; requests are ignored

## Operation
- Two-state FSM: INIT, READY. A 2-bit-wider-than-needed counter is not required; the sweep counter is AW bits.
- Reset (rst_n=0 at an edge): state=INIT, sweep counter=0, rdata_o=0, rvalid_o=0, rerr_o=0. Array contents are not reset directly.
- INIT: on each edge with rst_n=1, entry[cnt] <= INIT_VAL, cnt++. On the edge where cnt==DEPTH-1, state -> READY. wen_i, ren_i and clr_i are ignored; rvalid_o stays 0.
- READY, write: wen_i=1 and waddr_i<DEPTH -> entry[waddr_i] <= (entry & ~wmask_i) | (wdata_i & wmask_i). waddr_i>=DEPTH -> write dropped silently.
- READY, read: ren_i=1 -> rvalid_o=1 next cycle. raddr_i<DEPTH: rdata_o=entry[raddr_i], rerr_o=0. raddr_i>=DEPTH: rdata_o=0, rerr_o=1.
- Read and write to the same in-range address in the same cycle: BYPASS=1 -> rdata_o is the merged post-write value; BYPASS=0 -> pre-write value. The array is updated in both cases.
- No read: rvalid_o=0, rerr_o=0, rdata_o holds its last value.
- clr_i=1 in READY: next edge state -> INIT, cnt=0. Any wen_i/ren_i in that cycle is dropped; rvalid_o=0 next cycle.
- clr_i in INIT: ignored. The sweep is not restarted.

## Timing
- busy_o = (state==INIT), combinational from state. It is 1 during reset and for exactly DEPTH edges after the first edge with rst_n=1.
- Read latency: 1 clock, from request edge to rdata_o/rvalid_o. Back-to-back reads every cycle are supported; there are no bubbles.
- Write is visible to a read issued in the next cycle, and in the same cycle when BYPASS=1.
- Reset asserted mid-sweep or mid-read: at the next edge, all outputs return to reset values and the sweep restarts from entry 0.
- rdata_o, rvalid_o and rerr_o are flop outputs, with no combinational path from the inputs.

## Test plan
- Reset then release, DEPTH=4, INIT_VAL=8'hA5 -> busy_o high for 4 edges after release. Reads of addresses 0..3 then return A5 with rvalid_o pulses and rerr_o=0.
- Write addr 2 data 8'h3C mask 8'hFF, then write addr 2 data 8'hFF mask 8'h0F -> a read of addr 2 returns 8'h3F.
- Same-cycle write addr 1 data 8'h55 (entry holds 8'h00) and read addr 1 -> BYPASS=1 returns 8'h55 and BYPASS=0 returns 8'h00. A following read returns 8'h55 in both cases.
- DEPTH=5, AW=3: read addr 6 -> rvalid_o=1, rerr_o=1, rdata_o=0. Write addr 7 followed by reads of addresses 0..4 -> contents unchanged.
- clr_i pulse with concurrent wen_i to addr 0 -> write dropped, busy_o high for DEPTH edges, and all entries then read INIT_VAL. A clr_i pulse during the sweep does not extend busy_o.
- Continuous ren_i with rst_n pulsed low for 1 cycle mid-stream -> rvalid_o=0 and rdata_o=0 after the reset edge, busy_o high, and no rvalid_o until the sweep completes.
